// File: rtl/shift_frame_receiver_if.sv
// Serial input / word-output bundle for shift_frame_receiver.
// master = receiver side, slave = driver/consumer side.
`default_nettype none

interface shift_frame_receiver_if #(
  parameter int DATA_W = 8
);
  logic              ser_in;
  logic              ser_stb;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport master (
    input  ser_in, ser_stb, out_ready,
    output out_data, out_valid, frame_err, overrun, busy
  );

  modport slave (
    output ser_in, ser_stb, out_ready,
    input  out_data, out_valid, frame_err, overrun, busy
  );
endinterface

`default_nettype wire

// File: rtl/shift_frame_receiver.sv
// LSB-first strobed serial frame receiver with a one-entry valid/ready output buffer.
// Optional even parity bit enabled by defining SHIFT_FRAME_PARITY_EN.
`default_nettype none

module shift_frame_receiver #(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_frame_receiver_if.master bus
);

  localparam int                 CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SHIFT_FRAME_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_STOP   = 2'd2,
    S_PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_STOP   = 2'd2
  } state_t;
`endif

  state_t             r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_valid;
  logic               r_frame_err;
  logic               r_overrun;
  logic               r_busy;
`ifdef SHIFT_FRAME_PARITY_EN
  logic               r_par_bit;
`endif

  logic               w_pop;
  logic               w_good;
  logic [DATA_W-1:0]  w_shift_next;

  assign w_pop = r_out_valid & bus.out_ready;

  // Frame quality as judged on the stop-bit strobe (ser_in is the stop bit).
`ifdef SHIFT_FRAME_PARITY_EN
  assign w_good = bus.ser_in & ~((^r_shift) ^ r_par_bit);
`else
  assign w_good = bus.ser_in;
`endif

  // Right-shift insertion lands the first received bit at position 0 after DATA_W strobes.
  always_comb begin
    w_shift_next             = r_shift >> 1;
    w_shift_next[DATA_W-1]   = bus.ser_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SHIFT_FRAME_PARITY_EN
      r_par_bit   <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      if (w_pop) begin
        r_out_valid <= 1'b0;
      end
      if (bus.ser_stb) begin
        case (r_state)
          S_IDLE: begin
            if (!bus.ser_in) begin
              r_bit_cnt <= '0;
              r_state   <= S_DATA;
              r_busy    <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == LAST_BIT) begin
`ifdef SHIFT_FRAME_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
`ifdef SHIFT_FRAME_PARITY_EN
          S_PARITY: begin
            r_par_bit <= bus.ser_in;
            r_state   <= S_STOP;
          end
`endif
          S_STOP: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (w_good) begin
              // A pop on this same edge frees the slot, so the new word loads without a gap.
              if (!r_out_valid || w_pop) begin
                r_out_data  <= r_shift;
                r_out_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_shift_frame_receiver.sv
// Directed self-checking bench for shift_frame_receiver with an expected-word scoreboard.
`default_nettype none

module tb_shift_frame_receiver;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W-1:0] sb[$];

  shift_frame_receiver_if #(.DATA_W(DATA_W)) bus ();

  shift_frame_receiver #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.ser_in  = b;
    bus.ser_stb = 1'b1;
    tick();
    bus.ser_stb = 1'b0;
    bus.ser_in  = 1'b1;
  endtask

  // push: frame is expected to be loaded; pop_on_stop: consumer accepts on the stop-strobe cycle.
  task automatic send_frame(input logic [DATA_W-1:0] data, input logic stop_bit,
                            input logic par_flip, input logic push, input logic pop_on_stop);
    logic [DATA_W-1:0] exp_word;
    logic              expect_err;
    expect_err = ~stop_bit;
`ifdef SHIFT_FRAME_PARITY_EN
    expect_err = expect_err | par_flip;
`endif
    if (push) sb.push_back(data);
    send_bit(1'b0);
    check("busy_after_start", 16'(bus.busy), 16'd1);
    for (int i = 0; i < DATA_W; i++) send_bit(data[i]);
`ifdef SHIFT_FRAME_PARITY_EN
    send_bit((^data) ^ par_flip);
`endif
    if (pop_on_stop) begin
      check("valid_before_pop", 16'(bus.out_valid), 16'd1);
      exp_word = sb.pop_front();
      check("data_at_pop", 16'(bus.out_data), 16'(exp_word));
      bus.out_ready = 1'b1;
    end
    send_bit(stop_bit);
    bus.out_ready = 1'b0;
    check("busy_after_stop", 16'(bus.busy), 16'd0);
    check("frame_err_pulse", 16'(bus.frame_err), 16'(expect_err));
    if (expect_err) begin
      tick();
      check("frame_err_one_cycle", 16'(bus.frame_err), 16'd0);
    end
  endtask

  task automatic pop_word(input string tag);
    logic [DATA_W-1:0] exp_word;
    check({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb_empty: observed 0 entries expected 1", tag);
    end else begin
      exp_word = sb.pop_front();
      check({tag, "_data"}, 16'(bus.out_data), 16'(exp_word));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_valid_clear"}, 16'(bus.out_valid), 16'd0);
  endtask

  initial begin
    bus.ser_in    = 1'b1;
    bus.ser_stb   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset and idle
    rst = 1'b0;
    repeat (3) tick();
    check("rst_out_data", 16'(bus.out_data), 16'h0000);
    check("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("rst_frame_err", 16'(bus.frame_err), 16'd0);
    check("rst_overrun", 16'(bus.overrun), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      check("idle_busy", 16'(bus.busy), 16'd0);
      check("idle_valid", 16'(bus.out_valid), 16'd0);
      check("idle_frame_err", 16'(bus.frame_err), 16'd0);
    end

    // Basic receive, word held until accepted
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("basic_valid", 16'(bus.out_valid), 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("basic_hold_valid", 16'(bus.out_valid), 16'd1);
      check("basic_hold_data", 16'(bus.out_data), 16'h00A5);
    end
    pop_word("basic");

    // Bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("badstop_valid", 16'(bus.out_valid), 16'd0);
    check("badstop_overrun", 16'(bus.overrun), 16'd0);

    // Overrun, then load coincident with pop
    send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ovr_no_overrun_yet", 16'(bus.overrun), 16'd0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr_overrun", 16'(bus.overrun), 16'd1);
    check("ovr_data_kept", 16'(bus.out_data), 16'h0011);
    send_frame(8'h33, 1'b1, 1'b0, 1'b1, 1'b1);
    check("ovr_no_gap_valid", 16'(bus.out_valid), 16'd1);
    check("ovr_overrun_sticky", 16'(bus.overrun), 16'd1);
    pop_word("third");

`ifdef SHIFT_FRAME_PARITY_EN
    // Even parity: good then flipped parity bit
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    pop_word("par_good");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    check("par_bad_valid", 16'(bus.out_valid), 16'd0);
`endif

    // Reset mid-frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    check("midrst_busy_before", 16'(bus.busy), 16'd1);
    rst = 1'b0;
    #1;
    check("midrst_async_busy", 16'(bus.busy), 16'd0);
    tick();
    check("midrst_overrun", 16'(bus.overrun), 16'd0);
    check("midrst_frame_err", 16'(bus.frame_err), 16'd0);
    rst = 1'b1;
    tick();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    check("midrst_frame_err_after", 16'(bus.frame_err), 16'd0);
    pop_word("after_rst");

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_frame_receiver.md
# shift_frame_receiver

Serial frame receiver that sits directly downstream of the universal shift register. It consumes the register's LSB-first serial output (`LSB_out`, qualified by a per-bit strobe) and detects start bits. It reassembles `DATA_W`-bit frames, checks framing and optional even parity, and hands completed words to the consumer through a one-entry valid/ready output buffer.

## Interface
- `DATA_W`, 8, payload bits per frame (1..16)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-low reset
- `ser_in`  input  1  serial bit (driven from shift register `LSB_out`)
- `ser_stb`  input  1  bit strobe; `ser_in` is sampled only in cycles where `ser_stb`=1
- `out_data`  output  DATA_W  received payload, bit 0 = first data bit received
- `out_valid`  output  1  `out_data` holds an unconsumed word
- `out_ready`  input  1  consumer accepts word when `out_valid`&`out_ready`
- `frame_err`  output  1  one-cycle pulse: bad stop bit or parity mismatch
- `overrun`  output  1  sticky: a good frame was dropped because the buffer was full
- `busy`  output  1  state ≠ IDLE

## Operation
- States: IDLE, DATA, PARITY (only with macro), STOP.
- IDLE: on a strobe with `ser_in`=0 (start bit), clear the bit counter and go to DATA. Strobes with `ser_in`=1 are ignored.
- DATA: each strobe shifts `ser_in` into the shift buffer at position `bit_cnt`, LSB first, and increments `bit_cnt`. After strobe number `DATA_W`, go to PARITY if enabled, else STOP.
- PARITY: one strobe captures the parity bit, then go to STOP.
- STOP: one strobe samples the stop bit, then return to IDLE unconditionally.
  - Frame is good if stop=1 and, when enabled, the XOR of data bits and the parity bit is 0 (even parity).
  - Good frame with buffer empty, or buffer being popped in the same cycle: load `out_data`, set `out_valid`.
  - Good frame with buffer full and not popped: drop the frame, set `overrun`. `out_data` is unchanged.
  - Bad frame: pulse `frame_err` for 1 cycle and drop the frame. The buffer and `overrun` are untouched.
- Handshake: `out_valid` stays high and `out_data` stays stable until a cycle with `out_ready`=1. `out_valid` clears on the next edge unless a load happens in the same cycle.
- `overrun` is cleared only by reset.
- Cycles without a strobe never change state, counter, or shift buffer.
- Bit counter width is clog2(DATA_W+1). Counter wrap is impossible because it clears on every start bit.

## Timing
- Reset (async assert, sync deassert by the driver) values: state=IDLE, `out_data`=0, `out_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
- Reset asserted mid-frame aborts the frame immediately. No `frame_err` is reported.
- `busy` rises on the edge following the start-bit strobe.
- `out_valid` rises on the clock edge following the stop-bit strobe (1-cycle latency from the final strobe).
- `frame_err` and the `overrun` set occur on that same edge.
- Back-to-back frames are supported. A start bit may arrive on the strobe immediately after the stop strobe; the minimum strobe spacing is 1 cycle.
- All outputs are registered. There is no combinational path from `out_ready` to `out_valid`.

## Configuration
- `SHIFT_FRAME_PARITY_EN` defined: the PARITY state exists and frames are start + DATA_W + parity + stop. A parity mismatch is a `frame_err`.
- Not defined: the PARITY state and parity logic are absent. Frames are start + DATA_W + stop.

## Test plan
- Reset and idle: hold `rst`=0, then release and strobe `ser_in`=1 ×5. Required: all outputs 0 and `busy`=0 throughout.
- Basic receive (no parity, DATA_W=8): strobe 0, bits of 8'hA5 LSB first, then 1. Required: `out_valid`=1 one cycle after the stop strobe, `out_data`=8'hA5, and the word held until `out_ready`=1.
- Bad stop: send 8'h3C with stop bit 0. Required: `frame_err` pulses for exactly 1 cycle and `out_valid` stays 0.
- Overrun: receive 8'h11 and keep `out_ready`=0, then receive 8'h22. Required: `out_data`=8'h11 and `overrun`=1. Then set `out_ready`=1 on the exact cycle a third frame 8'h33 completes. Required: `out_data`=8'h33 with no gap in `out_valid`.
- Parity (macro defined): send 8'h07 with parity bit 1 and stop bit 1. Required: word accepted. Send 8'h07 with parity bit 0. Required: `frame_err` pulse and no load.
- Reset mid-frame: assert `rst` after 4 data strobes, release, then send 8'h5A. Required: `out_data`=8'h5A and no `frame_err`.
